// File: rtl/ad_sequencer.sv
// Conversion sequencer for two serial ADCs sharing reset, convst and sclk.
// Resets the ADCs, starts a conversion, waits out busy, then streams 8 words over valid/ready.
module ad_sequencer #(
  parameter int SCLK_DIV   = 2,
  parameter int RESET_CYC  = 4,
  parameter int CONVST_CYC = 2,
  parameter int BUSY_TO    = 1023
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst_n,
  input  logic        start,
  input  logic        ad1_busy,
  input  logic        ad2_busy,
  input  logic        ad1_douta,
  input  logic        ad1_doutb,
  input  logic        ad2_douta,
  input  logic        ad2_doutb,
  output logic        adx_convsta,
  output logic        adx_convstb,
  output logic        adx_reset,
  output logic        adx_sclk,
  output logic        ad1_ncs,
  output logic        ad2_ncs,
  output logic [31:0] out_data,
  output logic [2:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        seq_busy,
  output logic        err_timeout
);

  // state     | meaning
  // INIT      | adx_reset high for RESET_CYC cycles after reset
  // IDLE      | waiting for start
  // CONVST    | convst low for CONVST_CYC cycles
  // WAIT_RISE | waiting for both busy high, timeout running
  // WAIT_FALL | waiting for both busy low, timeout running
  // SHIFT     | lead-in then 16 sclk periods for the current word
  // HOLD      | word presented on out_data until accepted
  // DONE      | one idle cycle before IDLE
  typedef enum logic [2:0] {
    INIT, IDLE, CONVST, WAIT_RISE, WAIT_FALL, SHIFT, HOLD, DONE
  } state_t;

  localparam int MAX_AB  = (RESET_CYC > CONVST_CYC) ? RESET_CYC : CONVST_CYC;
  localparam int MAX_CD  = (BUSY_TO > SCLK_DIV) ? BUSY_TO : SCLK_DIV;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RESET_LD  = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] CONVST_LD = CW'(CONVST_CYC - 1);
  localparam logic [CW-1:0] TO_LD     = CW'(BUSY_TO - 1);
  localparam logic [CW-1:0] SCLK_LD   = CW'(SCLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   sra_q, sra_d;
  logic [15:0]   srb_q, srb_d;
  logic [2:0]    idx_q, idx_d;
  logic          err_q, err_d;

  logic cnt_zero;
  logic din_a, din_b;
  logic ncs_active;

  assign cnt_zero = (cnt_q == '0);
  assign din_a    = idx_q[2] ? ad2_douta : ad1_douta;
  assign din_b    = idx_q[2] ? ad2_doutb : ad1_doutb;

  always_ff @(posedge fpga_clk) begin
    if (!fpga_rst_n) begin
      state_q <= INIT;
      cnt_q   <= RESET_LD;
      sclk_q  <= 1'b1;
      bit_q   <= '0;
      sra_q   <= '0;
      srb_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      bit_q   <= bit_d;
      sra_q   <= sra_d;
      srb_q   <= srb_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    bit_d   = bit_q;
    sra_d   = sra_q;
    srb_d   = srb_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      INIT: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      IDLE: begin
        if (start) begin
          state_d = CONVST;
          cnt_d   = CONVST_LD;
        end
      end
      CONVST: begin
        if (cnt_zero) begin
          state_d = WAIT_RISE;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_RISE: begin
        if (cnt_zero) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (ad1_busy && ad2_busy) state_d = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (cnt_zero) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!ad1_busy && !ad2_busy) begin
          state_d = SHIFT;
          idx_d   = '0;
          bit_d   = '0;
          cnt_d   = SCLK_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT: begin
        // The lead-in wait is simply a high phase with no bits shifted yet.
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = SCLK_LD;
          if (sclk_q) begin
            if (bit_q == 5'd16) state_d = HOLD;
            else                sclk_d  = 1'b0;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 1'b1;
            sra_d  = {sra_q[14:0], din_a};
            srb_d  = {srb_q[14:0], din_b};
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          idx_d   = idx_q + 1'b1;
          bit_d   = '0;
          cnt_d   = SCLK_LD;
          state_d = (idx_q == 3'd7) ? DONE : SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ncs releases at the end of the last word's final high phase, before its HOLD.
  assign ncs_active  = (state_q == SHIFT) || ((state_q == HOLD) && (idx_q[1:0] != 2'd3));
  assign ad1_ncs     = !(ncs_active && !idx_q[2]);
  assign ad2_ncs     = !(ncs_active && idx_q[2]);
  assign adx_reset   = (state_q == INIT);
  assign adx_convsta = (state_q != CONVST);
  assign adx_convstb = (state_q != CONVST);
  assign adx_sclk    = sclk_q;
  assign out_data    = {srb_q, sra_q};
  assign out_idx     = idx_q;
  assign out_valid   = (state_q == HOLD);
  assign seq_busy    = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ad_sequencer.sv
// Randomized bench for ad_sequencer: ADC serial model, word scoreboard and per-cycle protocol checks.
module tb_ad_sequencer;
  localparam int SD    = 2;
  localparam int RST_C = 4;
  localparam int CV_C  = 2;
  localparam int TO    = 1023;

  logic fpga_clk = 1'b0, fpga_rst_n = 1'b0, start = 1'b0;
  logic ad1_busy = 1'b0, ad2_busy = 1'b0;
  logic ad1_douta = 1'b0, ad1_doutb = 1'b0, ad2_douta = 1'b0, ad2_doutb = 1'b0;
  logic out_ready = 1'b0;
  logic adx_convsta, adx_convstb, adx_reset, adx_sclk, ad1_ncs, ad2_ncs;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic out_valid, seq_busy, err_timeout;

  ad_sequencer #(.SCLK_DIV(SD), .RESET_CYC(RST_C), .CONVST_CYC(CV_C), .BUSY_TO(TO)) dut (
    .fpga_clk(fpga_clk), .fpga_rst_n(fpga_rst_n), .start(start),
    .ad1_busy(ad1_busy), .ad2_busy(ad2_busy),
    .ad1_douta(ad1_douta), .ad1_doutb(ad1_doutb), .ad2_douta(ad2_douta), .ad2_doutb(ad2_doutb),
    .adx_convsta(adx_convsta), .adx_convstb(adx_convstb), .adx_reset(adx_reset), .adx_sclk(adx_sclk),
    .ad1_ncs(ad1_ncs), .ad2_ncs(ad2_ncs), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .seq_busy(seq_busy), .err_timeout(err_timeout)
  );

  always #5 fpga_clk = ~fpga_clk;

  int nvec = 0, nmis = 0;
  logic [15:0] wa [2][4];
  logic [15:0] wb [2][4];
  logic [34:0] expq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ADC model: MSB of word 0 presented when ncs falls, next bit after each sclk rise.
  int ptr1 = 0, ptr2 = 0;
  logic a_psclk = 1'b1, a_pncs1 = 1'b1, a_pncs2 = 1'b1;

  function automatic logic wbit(input int adc, input bit sel_a, input int p);
    int w;
    logic [15:0] v;
    w = p / 16;
    if (w > 3) w = 3;
    v = sel_a ? wa[adc][w] : wb[adc][w];
    return v[4'(15 - (p % 16))];
  endfunction

  initial forever begin
    @(posedge fpga_clk); #1;
    if (adx_sclk === 1'b1 && a_psclk === 1'b0) begin
      if (ad1_ncs === 1'b0) ptr1++;
      if (ad2_ncs === 1'b0) ptr2++;
    end
    if (ad1_ncs === 1'b0 && a_pncs1 !== 1'b0) ptr1 = 0;
    if (ad2_ncs === 1'b0 && a_pncs2 !== 1'b0) ptr2 = 0;
    a_psclk = adx_sclk; a_pncs1 = ad1_ncs; a_pncs2 = ad2_ncs;
    ad1_douta = wbit(0, 1'b1, ptr1);
    ad1_doutb = wbit(0, 1'b0, ptr1);
    ad2_douta = wbit(1, 1'b1, ptr2);
    ad2_doutb = wbit(1, 1'b0, ptr2);
  end

  // Ready generator: 0 always ready, 1 random, 2 stall on idx 2.
  int rdy_mode = 0, stall = 0;
  initial forever begin
    @(posedge fpga_clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (out_valid === 1'b1 && out_idx == 3'd2 && stall < 20) stall++;
        out_ready = !(out_idx == 3'd2 && stall < 20);
      end
    endcase
  end

  // Per-cycle protocol monitor and scoreboard.
  logic mon_on = 1'b0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_sclk = 1'b1, p_ncs1 = 1'b1, p_ncs2 = 1'b1;
  logic [31:0] p_data = '0;
  logic [2:0]  p_idx = '0;
  int rises = 0, since = 0, stray = 0, xfer_cnt = 0, run2 = 0, last_run2 = 0;
  logic [31:0] got [8];

  initial forever begin
    logic [34:0] e;
    @(negedge fpga_clk);
    if (mon_on) begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_data, p_data);
        chk("hold_idx", {29'd0, out_idx}, {29'd0, p_idx});
      end
      if (p_valid && p_ready) chk("valid_drop", {31'd0, out_valid}, 32'd0);
      if (out_valid) chk("sclk_high_in_hold", {31'd0, adx_sclk}, 32'd1);
      chk("ncs_exclusive", {31'd0, ad1_ncs | ad2_ncs}, 32'd1);
      chk("convst_equal", {31'd0, adx_convsta ^ adx_convstb}, 32'd0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_word: got idx %0d data %h, required no word", out_idx, out_data);
        end else begin
          e = expq.pop_front();
          chk("word_idx", {29'd0, out_idx}, {29'd0, e[34:32]});
          chk("word_data", out_data, e[31:0]);
        end
        if (xfer_cnt < 8) got[xfer_cnt] = out_data;
        xfer_cnt++;
      end
      if (out_valid && out_idx == 3'd2) run2++;
      else if (run2 != 0) begin last_run2 = run2; run2 = 0; end
      if (adx_sclk && !p_sclk) begin
        if (ad1_ncs && ad2_ncs) stray++;
        else begin rises++; since = 0; end
      end else since++;
      if ((!ad1_ncs && p_ncs1) || (!ad2_ncs && p_ncs2)) rises = 0;
      if ((ad1_ncs && !p_ncs1) || (ad2_ncs && !p_ncs2)) begin
        chk("rises_per_ncs", rises, 64);
        chk("ncs_tail", since, SD);
      end
    end else begin
      rises = 0; run2 = 0;
    end
    p_valid = out_valid; p_ready = out_ready; p_sclk = adx_sclk;
    p_ncs1 = ad1_ncs; p_ncs2 = ad2_ncs; p_data = out_data; p_idx = out_idx;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_convsta"}, {31'd0, adx_convsta}, 32'd1);
    chk({tag, "_convstb"}, {31'd0, adx_convstb}, 32'd1);
    chk({tag, "_sclk"}, {31'd0, adx_sclk}, 32'd1);
    chk({tag, "_ncs"}, {30'd0, ad1_ncs, ad2_ncs}, 32'd3);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_idx"}, {29'd0, out_idx}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, "_busy"}, {31'd0, seq_busy}, 32'd1);
    chk({tag, "_adxreset"}, {31'd0, adx_reset}, 32'd1);
  endtask

  task automatic release_init();
    int n;
    n = 0;
    @(posedge fpga_clk); #1 fpga_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge fpga_clk);
      if (adx_reset === 1'b1) n++;
      else break;
    end
    chk("init_len", n, RST_C);
    chk("idle_after_init", {31'd0, seq_busy}, 32'd0);
  endtask

  task automatic rand_words();
    for (int a = 0; a < 2; a++)
      for (int w = 0; w < 4; w++) begin
        wa[a][w] = 16'($urandom);
        wb[a][w] = 16'($urandom);
      end
  endtask

  // busy_cyc 0: busy never rises (timeout). inject 1: start during SHIFT; 2: reset at idx 5 bit 7.
  task automatic do_conv(input int busy_cyc, input int inject);
    int n, r;
    logic ps;
    xfer_cnt = 0;
    if (busy_cyc > 0)
      for (int a = 0; a < 2; a++)
        for (int w = 0; w < 4; w++)
          expq.push_back({3'(a * 4 + w), wb[a][w], wa[a][w]});
    @(posedge fpga_clk); #1 start = 1'b1;
    @(posedge fpga_clk); #1 start = 1'b0;
    n = 0;
    while (adx_convsta !== 1'b1 && n < 50) begin
      n++;
      @(posedge fpga_clk); #1;
    end
    chk("convst_len", n, CV_C);
    if (busy_cyc == 0) begin
      n = 0;
      while (n < 3000) begin
        @(negedge fpga_clk);
        if (err_timeout === 1'b1) break;
        n++;
      end
      chk("timeout_cycle", n, TO);
      chk("timeout_idle", {31'd0, seq_busy}, 32'd0);
      chk("timeout_no_words", xfer_cnt, 0);
      return;
    end
    ad1_busy = 1'b1; ad2_busy = 1'b1;
    repeat (busy_cyc) @(posedge fpga_clk);
    #1 ad1_busy = 1'b0; ad2_busy = 1'b0;
    if (inject == 1) begin
      n = 0;
      while (xfer_cnt < 1 && n < 2000) begin n++; @(posedge fpga_clk); #1; end
      start = 1'b1;
      @(posedge fpga_clk); #1 start = 1'b0;
    end else if (inject == 2) begin
      n = 0;
      while (!(out_idx == 3'd5 && out_valid == 1'b0) && n < 4000) begin n++; @(posedge fpga_clk); #1; end
      r = 0; ps = adx_sclk;
      while (r < 7 && n < 5000) begin
        n++;
        @(posedge fpga_clk); #1;
        if (adx_sclk && !ps) r++;
        ps = adx_sclk;
      end
      chk("reached_bit7_idx5", r, 7);
      mon_on = 1'b0;
      fpga_rst_n = 1'b0;
      @(posedge fpga_clk);
      @(negedge fpga_clk);
      check_reset_vals("midreset");
      expq.delete();
      return;
    end
    n = 0;
    while (!(seq_busy === 1'b0 && expq.size() == 0) && n < 6000) begin n++; @(negedge fpga_clk); end
    chk("conv_complete", xfer_cnt, 8);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge fpga_clk);
    @(negedge fpga_clk);
    check_reset_vals("por");
    release_init();
    mon_on = 1'b1;

    wa[0][0] = 16'hA5A5; wa[0][1] = 16'h0001; wa[0][2] = 16'h8000; wa[0][3] = 16'hFFFF;
    wb[0][0] = 16'h1234; wb[0][1] = 16'h5678; wb[0][2] = 16'h9ABC; wb[0][3] = 16'hDEF0;
    wa[1][0] = 16'h0F0F; wa[1][1] = 16'hF0F0; wa[1][2] = 16'h0000; wa[1][3] = 16'h7FFE;
    wb[1][0] = 16'hCAFE; wb[1][1] = 16'hBEEF; wb[1][2] = 16'h0102; wb[1][3] = 16'hFEDC;
    rdy_mode = 0;
    do_conv(10, 0);
    chk("lit_word0", got[0], 32'h1234A5A5);
    chk("lit_word2", got[2], 32'h9ABC8000);
    chk("lit_word3", got[3], 32'hDEF0FFFF);
    chk("lit_word7", got[7], 32'hFEDC7FFE);
    chk("err_clear", {31'd0, err_timeout}, 32'd0);

    rand_words();
    stall = 0; rdy_mode = 2;
    do_conv(5, 0);
    chk("stall_hold_len", last_run2, 20);

    rdy_mode = 0;
    do_conv(0, 0);
    chk("err_set", {31'd0, err_timeout}, 32'd1);

    rand_words();
    do_conv(7, 0);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);

    rand_words();
    do_conv($urandom_range(1, 30), 1);
    n = 0;
    repeat (40) begin
      @(negedge fpga_clk);
      if (seq_busy) n++;
    end
    chk("start_not_queued", n, 0);

    rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      rand_words();
      do_conv($urandom_range(1, 40), 0);
    end

    rand_words();
    rdy_mode = 0;
    do_conv(6, 2);
    release_init();
    mon_on = 1'b1;
    chk("err_after_reset", {31'd0, err_timeout}, 32'd0);
    rand_words();
    do_conv(9, 0);

    chk("stray_sclk_rises", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
